// File: rtl/ss_stream_decoder_if.sv
`timescale 1ns/1ps
// Purpose : handshake/bus bundle between the signed stochastic decoder and its producer/consumer.
// Latency : n/a (wiring only).
// Backpr. : OUT_READY from the consumer; OUT_VALID/VALUE hold until accepted.
// Signals : START, IN, SIGN_IN, OUT_READY towards the decoder;
//           BUSY, OUT_VALID, VALUE, OVERRUN from the decoder.
// Modports: slave  = decoder side, master = producer/consumer side.
interface ss_stream_decoder_if #(
    parameter int VAL_W = 10
) ();
    logic                    START;
    logic                    IN;
    logic                    SIGN_IN;
    logic                    OUT_READY;
    logic                    BUSY;
    logic                    OUT_VALID;
    logic signed [VAL_W-1:0] VALUE;
    logic                    OVERRUN;

    modport slave (
        input  START, IN, SIGN_IN, OUT_READY,
        output BUSY, OUT_VALID, VALUE, OVERRUN
    );

    modport master (
        output START, IN, SIGN_IN, OUT_READY,
        input  BUSY, OUT_VALID, VALUE, OVERRUN
    );
endinterface

// File: rtl/ss_stream_decoder.sv
`timescale 1ns/1ps
// Purpose : count a signed stochastic bitstream (IN + SIGN_IN) over 2**WIN_LOG2 samples into a
//           two's-complement VALUE delivered over a valid/ready handshake.
// Latency : result visible 2**WIN_LOG2 edges after the START edge; held until accepted.
// Backpr. : one result pending in HOLD while the previous is unaccepted (no loss); with
//           SS_DEC_CONTINUOUS_EN the stream free-runs and overwrites, flagging OVERRUN.
// Ports   : CLK, INIT_n (async active-low) plain; bus (slave modport) carries START, IN,
//           SIGN_IN, OUT_READY in and BUSY, OUT_VALID, VALUE, OVERRUN out.
// Config  : `define SS_DEC_CONTINUOUS_EN for back-to-back windows after a single START.
module ss_stream_decoder #(
    parameter int WIN_LOG2 = 8,
    parameter int VAL_W    = WIN_LOG2 + 2
) (
    input  logic                 CLK,
    input  logic                 INIT_n,
    ss_stream_decoder_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [VAL_W-1:0] acc_q, acc_d;
    logic signed [VAL_W-1:0] value_q, value_d;
    logic signed [VAL_W-1:0] pend_q, pend_d;
    logic [WIN_LOG2-1:0]     cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;

    logic signed [VAL_W-1:0] step_val;
    logic signed [VAL_W-1:0] acc_sum;
    logic                    last_sample;
    logic                    accept;

    always_comb begin
        // +1 / -1 / 0 contribution of this cycle's sample; SIGN_IN only matters when IN=1.
        step_val = '0;
        if (bus.IN) begin
            step_val = bus.SIGN_IN ? {VAL_W{1'b1}} : VAL_W'(1);
        end
        acc_sum     = acc_q + step_val;
        last_sample = (cnt_q == {WIN_LOG2{1'b1}});
        accept      = out_valid_q & bus.OUT_READY;

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        value_d     = value_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q & ~accept;
        overrun_d   = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end

            ST_ACCUM: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + WIN_LOG2'(1);
                if (last_sample) begin
`ifdef SS_DEC_CONTINUOUS_EN
                    // Free-running: next window starts on this same edge.
                    value_d     = acc_sum;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    if (out_valid_q && !bus.OUT_READY) begin
                        overrun_d = 1'b1;
                    end
`else
                    if (!out_valid_q || bus.OUT_READY) begin
                        // Output register free (or being freed): new result wins.
                        value_d     = acc_sum;
                        out_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        // Previous result still owned by the consumer: park this one.
                        pend_d  = acc_sum;
                        state_d = ST_HOLD;
                    end
`endif
                end
            end

            ST_HOLD: begin
                // OUT_VALID is always 1 here, so OUT_READY alone is the handshake.
                if (bus.OUT_READY) begin
                    value_d     = pend_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge INIT_n) begin
        if (!INIT_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            value_q     <= '0;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.BUSY      = (state_q == ST_ACCUM);
    assign bus.OUT_VALID = out_valid_q;
    assign bus.VALUE     = value_q;
    assign bus.OVERRUN   = overrun_q;

endmodule

// File: tb/tb_ss_stream_decoder.sv
`timescale 1ns/1ps
// Purpose : randomized and directed checking of ss_stream_decoder against a window-sum model.
// Latency : n/a.
// Backpr. : drives OUT_READY low/high to exercise HOLD and (continuous build) OVERRUN.
module tb_ss_stream_decoder;
    localparam int WIN_LOG2 = 4;
    localparam int VAL_W    = 6;
    localparam int WIN      = 16;

    logic CLK    = 1'b0;
    logic INIT_n = 1'b0;
    always #5 CLK = ~CLK;

    ss_stream_decoder_if #(.VAL_W(VAL_W)) bus ();

    ss_stream_decoder #(.WIN_LOG2(WIN_LOG2), .VAL_W(VAL_W)) dut (
        .CLK    (CLK),
        .INIT_n (INIT_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_q[$];           // expected results, oldest first, popped on each accept
    bit in_a [WIN];
    bit sg_a [WIN];

    always @(posedge CLK) cyc++;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: a window's value is (#positive ones) - (#negative ones).
    function automatic int model_sum();
        int pos = 0;
        int neg = 0;
        for (int i = 0; i < WIN; i++) begin
            if (in_a[i] && !sg_a[i]) pos++;
            if (in_a[i] &&  sg_a[i]) neg++;
        end
        return pos - neg;
    endfunction

    // mode: 0 all +, 1 all -, 2 alternating sign, 3 12+ then 4-, 4 IN=0/SIGN=1,
    //       5 random, 6 p positives then n negatives then zeros with random sign.
    task automatic fill(input int mode, input int p, input int n);
        for (int i = 0; i < WIN; i++) begin
            case (mode)
                0: begin in_a[i] = 1'b1; sg_a[i] = 1'b0; end
                1: begin in_a[i] = 1'b1; sg_a[i] = 1'b1; end
                2: begin in_a[i] = 1'b1; sg_a[i] = i[0]; end
                3: begin in_a[i] = 1'b1; sg_a[i] = (i >= 12); end
                4: begin in_a[i] = 1'b0; sg_a[i] = 1'b1; end
                5: begin in_a[i] = 1'($urandom); sg_a[i] = 1'($urandom); end
                default: begin
                    in_a[i] = (i < p + n);
                    sg_a[i] = (i < p) ? 1'b0 : ((i < p + n) ? 1'b1 : 1'($urandom));
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Starts a window from IDLE and feeds in_a/sg_a; returns just after the result edge.
    task automatic run_window(input string tag);
        exp_q.push_back(model_sum());
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        check({tag, "_busy_start"}, bus.BUSY, 1);
        for (int k = 0; k < WIN; k++) begin
            bus.IN      = in_a[k];
            bus.SIGN_IN = sg_a[k];
            step();
            if (k == WIN - 2) begin
                check({tag, "_busy_mid"}, bus.BUSY, 1);
                if (exp_q.size() == 1) check({tag, "_early_valid"}, bus.OUT_VALID, 0);
            end
        end
        bus.IN = 1'b0;
        check({tag, "_busy_end"}, bus.BUSY, 0);
        check({tag, "_valid"}, bus.OUT_VALID, 1);
        check({tag, "_value"}, bus.VALUE, exp_q[0]);
    endtask

    // Accept scoreboard and stability of an unaccepted result.
    bit                    hold_prev = 1'b0;
    logic signed [VAL_W-1:0] prev_val;
    always @(negedge CLK) begin
        if (!INIT_n) begin
            hold_prev = 1'b0;
        end else begin
            if (bus.OUT_VALID && bus.OUT_READY) begin
                check("accept_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("accept_value", bus.VALUE, exp_q.pop_front());
            end
`ifndef SS_DEC_CONTINUOUS_EN
            if (hold_prev) begin
                check("stable_valid", bus.OUT_VALID, 1);
                check("stable_value", bus.VALUE, prev_val);
            end
`endif
            hold_prev = bus.OUT_VALID && !bus.OUT_READY;
            prev_val  = bus.VALUE;
        end
    end

    initial begin
        bus.START     = 1'b0;
        bus.IN        = 1'b0;
        bus.SIGN_IN   = 1'b0;
        bus.OUT_READY = 1'b1;
        #1;
        check("rst_busy",    bus.BUSY, 0);
        check("rst_valid",   bus.OUT_VALID, 0);
        check("rst_value",   bus.VALUE, 0);
        check("rst_overrun", bus.OVERRUN, 0);
        repeat (2) @(posedge CLK);
        #1 INIT_n = 1'b1;
        step();

`ifndef SS_DEC_CONTINUOUS_EN
        // Full positive window, one-cycle result with READY=1.
        fill(0, 0, 0);
        run_window("t1");
        step();
        check("t1_valid_drop", bus.OUT_VALID, 0);
        check("t1_idle", bus.BUSY, 0);

        // Directed patterns, then random windows.
        for (int m = 1; m <= 4; m++) begin
            fill(m, 0, 0);
            run_window($sformatf("t2_m%0d", m));
            step();
        end
        for (int r = 0; r < 8; r++) begin
            fill(5, 0, 0);
            bus.OUT_READY = 1'($urandom_range(0, 3) != 0);
            run_window($sformatf("t2_r%0d", r));
            bus.OUT_READY = 1'b1;
            step();
            step();
        end
        check("t2_drained", exp_q.size(), 0);

        // Back-pressure: +5 held, -3 parked in HOLD.
        bus.OUT_READY = 1'b0;
        fill(6, 5, 0);
        run_window("t3a");
        step();
        fill(6, 2, 5);
        run_window("t3b");
        repeat (3) step();
        check("t3_hold_value", bus.VALUE, 5);
        check("t3_hold_valid", bus.OUT_VALID, 1);
        check("t3_pending", exp_q.size(), 2);
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        check("t3_start_ignored", bus.BUSY, 0);
        bus.OUT_READY = 1'b1;
        step();
        check("t3_second_value", bus.VALUE, -3);
        check("t3_second_valid", bus.OUT_VALID, 1);
        step();
        check("t3_drop", bus.OUT_VALID, 0);
        check("t3_idle", bus.BUSY, 0);
        check("t3_drained", exp_q.size(), 0);

        // Reset during sample 9 discards the window.
        begin
            int seen = 0;
            fill(5, 0, 0);
            bus.START = 1'b1;
            step();
            bus.START = 1'b0;
            for (int k = 0; k < 9; k++) begin
                bus.IN = in_a[k]; bus.SIGN_IN = sg_a[k];
                step();
            end
            check("t4_busy_before", bus.BUSY, 1);
            #2 INIT_n = 1'b0;
            #1;
            check("t4_rst_busy",    bus.BUSY, 0);
            check("t4_rst_valid",   bus.OUT_VALID, 0);
            check("t4_rst_value",   bus.VALUE, 0);
            check("t4_rst_overrun", bus.OVERRUN, 0);
            @(posedge CLK);
            #1 INIT_n = 1'b1;
            bus.IN = 1'b0;
            for (int k = 0; k < 24; k++) begin
                step();
                if (bus.OUT_VALID) seen++;
            end
            check("t4_no_result", seen, 0);
            fill(5, 0, 0);
            run_window("t4");
            step();
        end

        // START held high: one result per 17 cycles.
        begin
            int rises = 0;
            int t_r [3];
            bit pv = 1'b0;
            for (int i = 0; i < 3; i++) exp_q.push_back(WIN);
            bus.IN = 1'b1; bus.SIGN_IN = 1'b0;
            bus.START = 1'b1;
            for (int c = 0; c < 120 && rises < 3; c++) begin
                @(negedge CLK);
                if (bus.OUT_VALID && !pv) begin
                    t_r[rises] = cyc;
                    rises++;
                end
                pv = bus.OUT_VALID;
            end
            bus.START = 1'b0;
            check("t5_rises", rises, 3);
            if (rises == 3) begin
                check("t5_period1", t_r[1] - t_r[0], 17);
                check("t5_period2", t_r[2] - t_r[1], 17);
            end
            step();
            bus.IN = 1'b0;
            repeat (3) step();
            check("t5_idle", bus.BUSY, 0);
            check("t5_drained", exp_q.size(), 0);
        end
        check("final_overrun", bus.OVERRUN, 0);
`else
        // Free-running stream, READY=0: overwrite flags OVERRUN from window 2 on.
        bus.OUT_READY = 1'b0;
        bus.IN = 1'b1; bus.SIGN_IN = 1'b0;
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            repeat (WIN) step();
            check($sformatf("c_w%0d_valid", w), bus.OUT_VALID, 1);
            check($sformatf("c_w%0d_value", w), bus.VALUE, WIN);
            check($sformatf("c_w%0d_busy", w), bus.BUSY, 1);
            check($sformatf("c_w%0d_overrun", w), bus.OVERRUN, (w >= 2));
        end
        bus.OUT_READY = 1'b1;
        repeat (5) step();
        check("c_overrun_sticky", bus.OVERRUN, 1);
        #2 INIT_n = 1'b0;
        #1;
        check("c_rst_overrun", bus.OVERRUN, 0);
        check("c_rst_busy", bus.BUSY, 0);
        exp_q.delete();
        @(posedge CLK);
        #1 INIT_n = 1'b1;
        // READY=1: every result consumed, OVERRUN stays low.
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            repeat (WIN - 1) step();
            exp_q.push_back(WIN);
            step();
            check($sformatf("c_r%0d_value", w), bus.VALUE, WIN);
            check($sformatf("c_r%0d_overrun", w), bus.OVERRUN, 0);
        end
        step();
        check("c_drained", exp_q.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
